fabric_cfg_loader: RTL and testbench

- Byte-serial configuration loader for fpga_top.
- Receives a framed bitstream (sync byte, packed payload, checksum) over a valid/ready byte stream.
- Deserializes the payload into a shadow register.
- On a good checksum, atomically commits the frame to the parallel select vectors (brbselect, bsbselect, lbselect, four io selects). Those vectors drive fpga_top directly, in place of bench-driven configuration.

---
 rtl/fabric_cfg_pkg.sv | 41 ++++
 rtl/fabric_cfg_loader_if.sv | 18 +
 rtl/fabric_cfg_shadow.sv | 50 +++++
 rtl/fabric_cfg_loader.sv | 150 +++++++++++++++
 tb/tb_fabric_cfg_loader.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fabric_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fabric_cfg_pkg
// Shared constants for the fabric configuration loader and its consumers:
// select-vector widths, frame geometry, field offsets inside the packed
// payload, the frame start byte and the loader FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package fabric_cfg_pkg;

    // Select vector widths
    localparam int BRB_W = 900;
    localparam int BSB_W = 1728;
    localparam int LB_W  = 80;
    localparam int IO_W  = 30;

    // Frame geometry: payload bits are packed LSB-first, byte 0 first
    localparam int TOTAL_BITS = BRB_W + BSB_W + LB_W + 4 * IO_W;   // 2828
    localparam int NBYTES     = (TOTAL_BITS + 7) / 8;              // 354
    localparam int CNT_W      = $clog2(NBYTES);

    // Field offsets inside the payload bit stream
    localparam int BRB_OFF    = 0;
    localparam int BSB_OFF    = BRB_OFF + BRB_W;                   // 900
    localparam int LB_OFF     = BSB_OFF + BSB_W;                   // 2628
    localparam int LEFT_OFF   = LB_OFF + LB_W;                     // 2708
    localparam int RIGHT_OFF  = LEFT_OFF + IO_W;                   // 2738
    localparam int TOP_OFF    = RIGHT_OFF + IO_W;                  // 2768
    localparam int BOTTOM_OFF = TOP_OFF + IO_W;                    // 2798

    // Frame start byte
    localparam logic [7:0] SYNC = 8'hA5;

    // Loader FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_CHK    = 2'd2,
        S_COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/fabric_cfg_loader_if.sv
// -----------------------------------------------------------------------------
// fabric_cfg_loader_if
// Valid/ready byte stream carrying configuration frames into the loader.
//   s_data  : stream byte               (master -> slave)
//   s_valid : s_data valid              (master -> slave)
//   s_ready : slave accepts a byte      (slave -> master)
// A byte transfers on a rising edge where s_valid && s_ready.
// -----------------------------------------------------------------------------
interface fabric_cfg_loader_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/fabric_cfg_shadow.sv
// -----------------------------------------------------------------------------
// fabric_cfg_shadow
// Byte-addressed NBYTES x 8 shadow register holding the frame being loaded,
// with the payload sliced into the select fields.
//   clk        : clock
//   we         : write byte wdata into slot addr
//   addr       : payload byte index
//   wdata      : payload byte
//   brb .. bottom : shadow field views (combinational slices)
// -----------------------------------------------------------------------------
module fabric_cfg_shadow
    import fabric_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [CNT_W-1:0] addr,
    input  logic [7:0]       wdata,
    output logic [BRB_W-1:0] brb,
    output logic [BSB_W-1:0] bsb,
    output logic [LB_W-1:0]  lb,
    output logic [IO_W-1:0]  left,
    output logic [IO_W-1:0]  right,
    output logic [IO_W-1:0]  top,
    output logic [IO_W-1:0]  bottom
);

    logic [NBYTES*8-1:0] mem;

    // NOTE: the shadow has no reset; its contents only become visible through
    // a commit, which always follows a full frame write, so resetting it would
    // only add reset fan-out to thousands of flops for no functional gain.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{addr, 3'b000} +: 8] <= wdata;
        end
    end

    assign brb    = mem[BRB_OFF    +: BRB_W];
    assign bsb    = mem[BSB_OFF    +: BSB_W];
    assign lb     = mem[LB_OFF     +: LB_W];
    assign left   = mem[LEFT_OFF   +: IO_W];
    assign right  = mem[RIGHT_OFF  +: IO_W];
    assign top    = mem[TOP_OFF    +: IO_W];
    assign bottom = mem[BOTTOM_OFF +: IO_W];

    // Padding bits only matter to the checksum, which is computed upstream.
    logic pad_unused;
    assign pad_unused = ^mem[NBYTES*8-1:TOTAL_BITS];

endmodule

// File: rtl/fabric_cfg_loader.sv
// -----------------------------------------------------------------------------
// fabric_cfg_loader
// Byte-serial configuration loader. Accepts a frame (SYNC, NBYTES payload
// bytes, XOR checksum) and, on a good checksum, commits the payload to the
// active select vectors in one cycle.
//   clk, rst       : clock, asynchronous active-high reset
//   strm           : valid/ready byte stream (slave side)
//   abort          : synchronous frame abort (honoured in LOAD and CHK)
//   brbselect .. bottomioselect : active configuration outputs
//   cfg_busy       : frame in progress (state != IDLE)
//   cfg_done       : one-cycle pulse after a commit
//   cfg_err        : sticky, last frame failed its checksum
// -----------------------------------------------------------------------------
module fabric_cfg_loader
    import fabric_cfg_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fabric_cfg_loader_if.slave strm,
    input  logic               abort,
    output logic [BRB_W-1:0]   brbselect,
    output logic [BSB_W-1:0]   bsbselect,
    output logic [LB_W-1:0]    lbselect,
    output logic [IO_W-1:0]    leftioselect,
    output logic [IO_W-1:0]    rightioselect,
    output logic [IO_W-1:0]    topioselect,
    output logic [IO_W-1:0]    bottomioselect,
    output logic               cfg_busy,
    output logic               cfg_done,
    output logic               cfg_err
);

    localparam logic [1:0] ST_IDLE   = 2'(S_IDLE);
    localparam logic [1:0] ST_LOAD   = 2'(S_LOAD);
    localparam logic [1:0] ST_CHK    = 2'(S_CHK);
    localparam logic [1:0] ST_COMMIT = 2'(S_COMMIT);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       csum;
    logic             accept;
    logic             shadow_we;

    logic [BRB_W-1:0] sh_brb;
    logic [BSB_W-1:0] sh_bsb;
    logic [LB_W-1:0]  sh_lb;
    logic [IO_W-1:0]  sh_left;
    logic [IO_W-1:0]  sh_right;
    logic [IO_W-1:0]  sh_top;
    logic [IO_W-1:0]  sh_bottom;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        strm.s_ready = 1'b1;
        if (state == ST_COMMIT) begin
            strm.s_ready = 1'b0;
        end
    end

    assign accept    = strm.s_valid && strm.s_ready;
    assign cfg_busy  = (state != ST_IDLE);
    // Abort wins over a same-cycle byte, so that byte never reaches the shadow.
    assign shadow_we = (state == ST_LOAD) && strm.s_valid && !abort;

    fabric_cfg_shadow u_shadow (
        .clk    (clk),
        .we     (shadow_we),
        .addr   (cnt),
        .wdata  (strm.s_data),
        .brb    (sh_brb),
        .bsb    (sh_bsb),
        .lb     (sh_lb),
        .left   (sh_left),
        .right  (sh_right),
        .top    (sh_top),
        .bottom (sh_bottom)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            csum           <= '0;
            cfg_done       <= 1'b0;
            cfg_err        <= 1'b0;
            brbselect      <= '0;
            bsbselect      <= '0;
            lbselect       <= '0;
            leftioselect   <= '0;
            rightioselect  <= '0;
            topioselect    <= '0;
            bottomioselect <= '0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && strm.s_data == SYNC) begin
                        cnt     <= '0;
                        csum    <= '0;
                        cfg_err <= 1'b0;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        csum <= csum ^ strm.s_data;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            state <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        if (strm.s_data == csum) begin
                            state <= ST_COMMIT;
                        end else begin
                            cfg_err <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_COMMIT: begin
                    // All fields switch on the same edge: the fabric never
                    // sees a mix of old and new configuration.
                    brbselect      <= sh_brb;
                    bsbselect      <= sh_bsb;
                    lbselect       <= sh_lb;
                    leftioselect   <= sh_left;
                    rightioselect  <= sh_right;
                    topioselect    <= sh_top;
                    bottomioselect <= sh_bottom;
                    cfg_done       <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_fabric_cfg_loader
// Self-checking bench for fabric_cfg_loader. A frame-level model holds the
// expected active configuration and status; a compare process checks the DUT
// against it on every falling edge, and literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_fabric_cfg_loader;
    import fabric_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic abort;

    always #5 clk = ~clk;

    fabric_cfg_loader_if bus ();

    logic [BRB_W-1:0] brbselect;
    logic [BSB_W-1:0] bsbselect;
    logic [LB_W-1:0]  lbselect;
    logic [IO_W-1:0]  leftioselect;
    logic [IO_W-1:0]  rightioselect;
    logic [IO_W-1:0]  topioselect;
    logic [IO_W-1:0]  bottomioselect;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_err;

    fabric_cfg_loader dut (
        .clk            (clk),
        .rst            (rst),
        .strm           (bus),
        .abort          (abort),
        .brbselect      (brbselect),
        .bsbselect      (bsbselect),
        .lbselect       (lbselect),
        .leftioselect   (leftioselect),
        .rightioselect  (rightioselect),
        .topioselect    (topioselect),
        .bottomioselect (bottomioselect),
        .cfg_busy       (cfg_busy),
        .cfg_done       (cfg_done),
        .cfg_err        (cfg_err)
    );

    // Active config in spec field order: brb lowest, bottom highest.
    logic [TOTAL_BITS-1:0] dut_cfg;
    assign dut_cfg = {bottomioselect, topioselect, rightioselect, leftioselect,
                      lbselect, bsbselect, brbselect};

    // Frame-level model
    logic [TOTAL_BITS-1:0] exp_cfg;
    logic                  exp_done;
    logic                  exp_err;
    logic                  exp_busy;
    logic                  exp_ready;
    logic [7:0]            pay [NBYTES];

    int  checks    = 0;
    int  errors    = 0;
    int  done_seen = 0;
    bit  chk_en    = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Compare process: outputs are meaningful on every cycle after reset.
    int diff;
    always @(negedge clk) begin
        if (chk_en) begin
            diff = -1;
            for (int k = TOTAL_BITS - 1; k >= 0; k--) begin
                if (dut_cfg[k] !== exp_cfg[k]) diff = k;
            end
            check("cfg_first_bad_bit", 64'(diff), 64'(-1));
            check("cfg_done", 64'(cfg_done), 64'(exp_done));
            check("cfg_err", 64'(cfg_err), 64'(exp_err));
            check("cfg_busy", 64'(cfg_busy), 64'(exp_busy));
            check("s_ready", 64'(bus.s_ready), 64'(exp_ready));
            if (cfg_done === 1'b1) done_seen++;
        end
    end

    function automatic logic [7:0] calc_csum();
        logic [7:0] r = 8'h00;
        for (int i = 0; i < NBYTES; i++) r ^= pay[i];
        return r;
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < NBYTES; i++) pay[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NBYTES; i++) pay[i] = 8'($urandom);
    endtask

    // Inputs change 1 ns after the rising edge; a pending done pulse is over.
    task automatic tick();
        @(posedge clk);
        #1;
        exp_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
        tick();
    endtask

    task automatic do_abort();
        abort       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h77;
        tick();
        abort       = 1'b0;
        bus.s_valid = 1'b0;
        exp_busy    = 1'b0;
    endtask

    task automatic start_frame();
        send_byte(SYNC);
        exp_busy = 1'b1;
        exp_err  = 1'b0;
    endtask

    // abort_at: payload index at which to abort, NBYTES aborts in the
    // checksum phase, -1 runs the frame to the end.
    task automatic send_frame(input logic [7:0] ck, input bit gaps, input int abort_at);
        start_frame();
        for (int i = 0; i < NBYTES; i++) begin
            if (i == abort_at) begin
                do_abort();
                return;
            end
            if (gaps && (i % 2 == 1)) idle();
            send_byte(pay[i]);
        end
        if (abort_at == NBYTES) begin
            do_abort();
            return;
        end
        send_byte(ck);
        if (ck == calc_csum()) begin
            exp_ready = 1'b0;
            idle();
            for (int k = 0; k < TOTAL_BITS; k++) exp_cfg[k] = pay[k / 8][k % 8];
            exp_done  = 1'b1;
            exp_busy  = 1'b0;
            exp_ready = 1'b1;
        end else begin
            exp_err  = 1'b1;
            exp_busy = 1'b0;
        end
    endtask

    // Reset asserted 3 ns into a cycle, well away from any clock edge.
    task automatic async_reset();
        #3;
        rst       = 1'b1;
        exp_cfg   = '0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_busy  = 1'b0;
        exp_ready = 1'b1;
        #1;
        check("rst_cfg_zero_now", 64'(dut_cfg === '0), 64'd1);
        check("rst_done_low_now", 64'(cfg_done), 64'd0);
        check("rst_busy_low_now", 64'(cfg_busy), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
    endtask

    int seen_before;

    initial begin
        rst         = 1'b1;
        abort       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        exp_cfg     = '0;
        exp_done    = 1'b0;
        exp_err     = 1'b0;
        exp_busy    = 1'b0;
        exp_ready   = 1'b1;
        #12;
        rst = 1'b0;
        tick();
        chk_en = 1'b1;

        // Reset state, then non-SYNC bytes are ignored
        check("reset_cfg_zero", 64'(dut_cfg === '0), 64'd1);
        check("reset_ready", 64'(bus.s_ready), 64'd1);
        check("reset_busy", 64'(cfg_busy), 64'd0);
        send_byte(8'h00);
        send_byte(8'h3C);
        check("nosync_busy", 64'(cfg_busy), 64'd0);
        check("nosync_cfg_zero", 64'(dut_cfg === '0), 64'd1);

        // Frame A: byte 0 = 0x30 -> brb bits 4,5
        fill(8'h00);
        pay[0] = 8'h30;
        check("model_csum_a", 64'(calc_csum()), 64'h30);
        send_frame(8'h30, 1'b0, -1);
        check("a_done_now", 64'(cfg_done), 64'd1);
        check("a_brb_low", 64'(brbselect[15:0]), 64'h0030);
        check("a_brb_rest", 64'(|brbselect[BRB_W-1:16]), 64'd0);
        check("a_others", 64'(|dut_cfg[TOTAL_BITS-1:BRB_W]), 64'd0);
        idle();
        check("a_done_count", 64'(done_seen), 64'd1);
        check("a_err", 64'(cfg_err), 64'd0);

        // Frame B: byte 338 bit 6 = stream bit 2710 -> leftioselect[2], gaps
        fill(8'h00);
        pay[338] = 8'h40;
        check("model_csum_b", 64'(calc_csum()), 64'h40);
        send_frame(8'h40, 1'b1, -1);
        check("b_left", 64'(leftioselect), 64'd4);
        check("b_brb_zero", 64'(|brbselect), 64'd0);
        check("b_right_zero", 64'(rightioselect), 64'd0);

        // Frame C: all 0xFF with wrong checksum 0x01 (correct is 0x00)
        fill(8'hFF);
        check("model_csum_c", 64'(calc_csum()), 64'h00);
        send_frame(8'h01, 1'b0, -1);
        idle();
        idle();
        check("c_err", 64'(cfg_err), 64'd1);
        check("c_left_kept", 64'(leftioselect), 64'd4);
        check("c_done_count", 64'(done_seen), 64'd2);

        // Frames D and E back to back; D carries a SYNC-valued payload byte
        fill_random();
        pay[5] = SYNC;
        send_frame(calc_csum(), 1'b0, -1);
        fill_random();
        send_frame(calc_csum(), 1'b0, -1);
        idle();
        check("de_done_count", 64'(done_seen), 64'd4);

        // Abort after 100 payload bytes, then the same frame in full
        fill_random();
        send_frame(calc_csum(), 1'b0, 100);
        idle();
        check("abort_idle", 64'(cfg_busy), 64'd0);
        send_frame(calc_csum(), 1'b0, -1);
        idle();

        // Abort in the checksum phase
        fill_random();
        send_frame(calc_csum(), 1'b0, NBYTES);
        idle();

        // Reset mid-LOAD, then a fresh frame
        fill_random();
        start_frame();
        for (int i = 0; i < 50; i++) send_byte(pay[i]);
        async_reset();
        send_frame(calc_csum(), 1'b0, -1);
        idle();

        // Reset during COMMIT: no done pulse, outputs cleared
        fill_random();
        start_frame();
        for (int i = 0; i < NBYTES; i++) send_byte(pay[i]);
        send_byte(calc_csum());
        exp_ready   = 1'b0;
        seen_before = done_seen;
        async_reset();
        idle();
        idle();
        check("commit_rst_no_done", 64'(done_seen), 64'(seen_before));
        send_frame(calc_csum(), 1'b0, -1);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
